// File: rtl/dataflow_channel_pkg.sv
// -----------------------------------------------------------------------------
// dataflow_channel_pkg
// Shared definitions for the dataflow channel FIFO: default payload width and
// entry count, plus a ceil(log2) helper that sizes the FIFO pointers.
// No ports (package).
// -----------------------------------------------------------------------------
package dataflow_channel_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_DEPTH      = 4;

    // Smallest w such that 2**w >= value; used at elaboration time only.
    function automatic int clog2_width(input int value);
        int w;
        for (w = 0; (1 << w) < value; w++) begin
        end
        return w;
    endfunction

endpackage : dataflow_channel_pkg

// File: rtl/dataflow_channel_mem.sv
// -----------------------------------------------------------------------------
// dataflow_channel_mem
// DEPTH x DATA_WIDTH storage array for the channel FIFO: one synchronous write
// port and one asynchronous (combinational) read port.
// Ports:
//   clock      - write clock, rising edge
//   wr_en_i    - write strobe
//   wr_addr_i  - write address
//   wr_data_i  - write data
//   rd_addr_i  - read address
//   rd_data_o  - read data, combinational from rd_addr_i
// -----------------------------------------------------------------------------
module dataflow_channel_mem
    import dataflow_channel_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = clog2_width(DEPTH)
) (
    input  logic                  clock,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset; occupancy is tracked by the pointers and
    // count, so stale contents are never observed and the array can map to
    // plain RAM/flops without a reset tree.
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule : dataflow_channel_mem

// File: rtl/dataflow_channel_fifo.sv
// -----------------------------------------------------------------------------
// dataflow_channel_fifo
// First-word-fall-through FIFO channel between a producer and a consumer, with
// registered status flags, an occupancy count, a sticky high-water mark and
// per-cycle stall indicators.
// Ports:
//   clock      - single clock, all state updates on rising edge
//   reset      - asynchronous, active-low reset
//   i_write    - producer write request
//   i_din      - producer data
//   i_full_n   - high when an entry is free (registered)
//   t_read     - consumer read request
//   t_dout     - head-of-queue data, valid while t_empty_n is high
//   t_empty_n  - high when t_dout is valid (registered)
//   count      - current occupancy (registered)
//   peak       - sticky high-water mark of count, saturates at DEPTH
//   wr_stall   - last cycle had i_write high while i_full_n was low
//   rd_stall   - last cycle had t_read high while t_empty_n was low
// -----------------------------------------------------------------------------
module dataflow_channel_fifo
    import dataflow_channel_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    // Derived from DEPTH; leave at its default.
    parameter int ADDR_WIDTH = clog2_width(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_write,
    input  logic [DATA_WIDTH-1:0] i_din,
    output logic                  i_full_n,
    input  logic                  t_read,
    output logic [DATA_WIDTH-1:0] t_dout,
    output logic                  t_empty_n,
    output logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH:0]   peak,
    output logic                  wr_stall,
    output logic                  rd_stall
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH:0]   peak_q, peak_d;
    logic                  full_n_q;
    logic                  empty_n_q;
    logic                  wr_stall_q;
    logic                  rd_stall_q;

    logic wr_accept;
    logic rd_accept;

    // Acceptance is qualified only by the registered flags, so on a full FIFO
    // a simultaneous write is refused while the read proceeds, and on an
    // empty FIFO the read is refused while the write proceeds.
    assign wr_accept = i_write & full_n_q;
    assign rd_accept = t_read & empty_n_q;

    // NOTE: every variable driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // Pointers are ADDR_WIDTH bits and DEPTH is a power of two, so the
        // increment wraps from DEPTH-1 to 0 on its own.
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Compare against the next count so peak tracks count on the same
        // edge; count never exceeds DEPTH, so peak saturates there too.
        peak_d = (count_d > peak_q) ? count_d : peak_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            peak_q     <= '0;
            full_n_q   <= 1'b1;
            empty_n_q  <= 1'b0;
            wr_stall_q <= 1'b0;
            rd_stall_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            peak_q     <= peak_d;
            // Flags are registered from the next count so they never depend
            // combinationally on i_write or t_read.
            full_n_q   <= (count_d != FULL_COUNT);
            empty_n_q  <= (count_d != '0);
            wr_stall_q <= i_write & ~full_n_q;
            rd_stall_q <= t_read & ~empty_n_q;
        end
    end

    dataflow_channel_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clock     (clock),
        .wr_en_i   (wr_accept),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (i_din),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (t_dout)
    );

    assign i_full_n  = full_n_q;
    assign t_empty_n = empty_n_q;
    assign count     = count_q;
    assign peak      = peak_q;
    assign wr_stall  = wr_stall_q;
    assign rd_stall  = rd_stall_q;

endmodule : dataflow_channel_fifo

// File: tb/tb_dataflow_channel_fifo.sv
// -----------------------------------------------------------------------------
// tb_dataflow_channel_fifo
// Self-checking bench for dataflow_channel_fifo at DEPTH=4, DATA_WIDTH=32.
// A table of directed vectors covers fill, full-write refusal, drain, empty
// read refusal, simultaneous access at both boundaries and stall flags; short
// hand-written sequences cover pointer wrap and asynchronous mid-run reset.
// -----------------------------------------------------------------------------
module tb_dataflow_channel_fifo;

    localparam int DW = 32;
    localparam int DP = 4;
    localparam int AW = 2;

    logic          clock;
    logic          reset;
    logic          i_write;
    logic [DW-1:0] i_din;
    logic          i_full_n;
    logic          t_read;
    logic [DW-1:0] t_dout;
    logic          t_empty_n;
    logic [AW:0]   count;
    logic [AW:0]   peak;
    logic          wr_stall;
    logic          rd_stall;

    int n_vectors;
    int n_miscompares;

    dataflow_channel_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DP)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .i_write   (i_write),
        .i_din     (i_din),
        .i_full_n  (i_full_n),
        .t_read    (t_read),
        .t_dout    (t_dout),
        .t_empty_n (t_empty_n),
        .count     (count),
        .peak      (peak),
        .wr_stall  (wr_stall),
        .rd_stall  (rd_stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       wr;
        logic [7:0] din;
        logic       rd;
        logic       full_n;
        logic       empty_n;
        logic [2:0] cnt;
        logic [2:0] pk;
        logic       dout_chk;
        logic [7:0] dout;
        logic       ws;
        logic       rs;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive inputs away from the edge, clock once, sample 1ns after the edge.
    task automatic step(input logic wr, input logic [7:0] din, input logic rd);
        i_write = wr;
        i_din   = {24'h0, din};
        t_read  = rd;
        @(posedge clock);
        #1;
        i_write = 1'b0;
        t_read  = 1'b0;
    endtask

    task automatic do_reset();
        i_write = 1'b0;
        t_read  = 1'b0;
        i_din   = '0;
        reset   = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;

        //               wr din    rd fn en cnt pk chk dout   ws rs
        vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 3'd1, 3'd1, 1'b1, 8'h11, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 3'd2, 3'd2, 1'b1, 8'h11, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 3'd3, 3'd3, 1'b1, 8'h11, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 3'd4, 3'd4, 1'b1, 8'h11, 1'b0, 1'b0};
        // write into a full FIFO: refused, head unchanged, stall flagged
        vecs[5]  = '{1'b1, 8'h99, 1'b0, 1'b0, 1'b1, 3'd4, 3'd4, 1'b1, 8'h11, 1'b1, 1'b0};
        // drain: head advances 22, 33, 44, then empty; peak holds 4
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd3, 3'd4, 1'b1, 8'h22, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd2, 3'd4, 1'b1, 8'h33, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd1, 3'd4, 1'b1, 8'h44, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 3'd4, 1'b0, 8'h00, 1'b0, 1'b0};
        // read on empty: refused, stall flagged
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 3'd4, 1'b0, 8'h00, 1'b0, 1'b1};
        // empty + simultaneous: write wins, read ignored
        vecs[11] = '{1'b1, 8'h66, 1'b1, 1'b1, 1'b1, 3'd1, 3'd4, 1'b1, 8'h66, 1'b0, 1'b1};
        // idle: stall flag clears (not sticky)
        vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 3'd1, 3'd4, 1'b1, 8'h66, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 3'd2, 3'd4, 1'b1, 8'h66, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 3'd3, 3'd4, 1'b1, 8'h66, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 3'd4, 3'd4, 1'b1, 8'h66, 1'b0, 1'b0};
        // full + simultaneous: read wins (0x66 consumed), 0x55 dropped
        vecs[16] = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 3'd3, 3'd4, 1'b1, 8'h22, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 3'd3, 3'd4, 1'b1, 8'h22, 1'b0, 1'b0};
        // remaining entries are exactly 22, 33, 44: 0x55 never stored
        vecs[18] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd2, 3'd4, 1'b1, 8'h33, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd1, 3'd4, 1'b1, 8'h44, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 3'd4, 1'b0, 8'h00, 1'b0, 1'b0};

        do_reset();
        #1;
        check("reset full_n", {31'h0, i_full_n}, 32'h1);
        check("reset empty_n", {31'h0, t_empty_n}, 32'h0);
        check("reset count", {29'h0, count}, 32'h0);
        check("reset peak", {29'h0, peak}, 32'h0);
        check("reset wr_stall", {31'h0, wr_stall}, 32'h0);
        check("reset rd_stall", {31'h0, rd_stall}, 32'h0);

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].wr, vecs[i].din, vecs[i].rd);
            check($sformatf("v%0d full_n", i), {31'h0, i_full_n}, {31'h0, vecs[i].full_n});
            check($sformatf("v%0d empty_n", i), {31'h0, t_empty_n}, {31'h0, vecs[i].empty_n});
            check($sformatf("v%0d count", i), {29'h0, count}, {29'h0, vecs[i].cnt});
            check($sformatf("v%0d peak", i), {29'h0, peak}, {29'h0, vecs[i].pk});
            check($sformatf("v%0d wr_stall", i), {31'h0, wr_stall}, {31'h0, vecs[i].ws});
            check($sformatf("v%0d rd_stall", i), {31'h0, rd_stall}, {31'h0, vecs[i].rs});
            if (vecs[i].dout_chk) begin
                check($sformatf("v%0d t_dout", i), t_dout, {24'h0, vecs[i].dout});
            end
        end

        // ---------------- wrap: 10 write/read pairs after fresh reset --------
        do_reset();
        for (int i = 0; i < 10; i++) begin
            logic [7:0] val;
            val = 8'hA0 + 8'(i);
            step(1'b1, val, 1'b0);
            check($sformatf("wrap%0d count after write", i), {29'h0, count}, 32'h1);
            check($sformatf("wrap%0d t_dout", i), t_dout, {24'h0, val});
            step(1'b0, 8'h00, 1'b1);
            check($sformatf("wrap%0d count after read", i), {29'h0, count}, 32'h0);
        end
        check("wrap peak", {29'h0, peak}, 32'h1);
        check("wrap empty_n", {31'h0, t_empty_n}, 32'h0);

        // ---------------- asynchronous reset mid-operation ----------------
        step(1'b1, 8'hC1, 1'b0);
        step(1'b1, 8'hC2, 1'b0);
        step(1'b1, 8'hC3, 1'b0);
        check("pre-reset count", {29'h0, count}, 32'h3);
        // Now 1ns after a rising edge; clock stays high until +4ns.
        reset = 1'b0;
        #2;
        check("async reset full_n", {31'h0, i_full_n}, 32'h1);
        check("async reset empty_n", {31'h0, t_empty_n}, 32'h0);
        check("async reset count", {29'h0, count}, 32'h0);
        check("async reset peak", {29'h0, peak}, 32'h0);
        #1;
        reset = 1'b1;
        // First edge after release with no requests: nothing accepted.
        step(1'b0, 8'h00, 1'b0);
        check("post-reset idle count", {29'h0, count}, 32'h0);
        check("post-reset idle empty_n", {31'h0, t_empty_n}, 32'h0);
        // Queue restarts cleanly: new data is the head.
        step(1'b1, 8'hD7, 1'b0);
        check("post-reset write t_dout", t_dout, 32'hD7);
        check("post-reset write count", {29'h0, count}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule : tb_dataflow_channel_fifo

// File: doc/dataflow_channel_fifo.md
DATAFLOW_CHANNEL_FIFO -- requirements
Module: dataflow_channel_fifo

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 32, as the payload width in bits.
REQ-002 The block SHALL take parameter DEPTH, default 4, as the entry count; it SHALL be a power of two, 2..1024.
REQ-003 The block SHALL take parameter ADDR_WIDTH, default log2(DEPTH), as the pointer width; it is derived, not user-set.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port i_write, input, 1 bit: producer write request.
REQ-007 The block SHALL have port i_din, input, DATA_WIDTH bits: producer data.
REQ-008 The block SHALL have port i_full_n, output, 1 bit: high when an entry is free.
REQ-009 The block SHALL have port t_read, input, 1 bit: consumer read request.
REQ-010 The block SHALL have port t_dout, output, DATA_WIDTH bits: head-of-queue data.
REQ-011 The block SHALL have port t_empty_n, output, 1 bit: high when t_dout is valid.
REQ-012 The block SHALL have port count, output, ADDR_WIDTH+1 bits: current occupancy.
REQ-013 The block SHALL have port peak, output, ADDR_WIDTH+1 bits: sticky high-water mark of count.
REQ-014 The block SHALL have port wr_stall, output, 1 bit: registered flag, i_write high while i_full_n low in the previous cycle.
REQ-015 The block SHALL have port rd_stall, output, 1 bit: registered flag, t_read high while t_empty_n low in the previous cycle.

Function
REQ-016 A write SHALL be accepted when i_write=1 and i_full_n=1 at a clock edge; a read SHALL be accepted when t_read=1 and t_empty_n=1.
REQ-017 Ordering SHALL be first-word-fall-through: t_dout SHALL present the oldest entry whenever t_empty_n=1, with no read needed to expose it.
REQ-018 Write-to-read latency SHALL be one cycle: data accepted at edge N SHALL appear with t_empty_n=1 after edge N.
REQ-019 i_full_n, t_empty_n and count SHALL be registered, never combinational from i_write or t_read.
REQ-020 count SHALL change by +1 (write only), -1 (read only), or 0 (both or neither) at each edge.
REQ-021 On a full FIFO with i_write=1 and t_read=1, the read SHALL be accepted and the write rejected; count SHALL fall to DEPTH-1.
REQ-022 On an empty FIFO with i_write=1 and t_read=1, the write SHALL be accepted and the read ignored; count SHALL become 1.
REQ-023 A rejected write SHALL leave storage and pointers unchanged; a rejected read SHALL leave t_dout unchanged.
REQ-024 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-025 i_full_n SHALL equal (count != DEPTH) and t_empty_n SHALL equal (count != 0).
REQ-026 peak SHALL update to count whenever count exceeds it and SHALL saturate at DEPTH.
REQ-027 wr_stall and rd_stall SHALL be recomputed every cycle; they are not sticky.

Reset
REQ-028 Reset SHALL clear count, peak, pointers, wr_stall and rd_stall to 0, drive i_full_n=1 and t_empty_n=0, and leave storage contents undefined.
REQ-029 Reset asserted mid-transfer SHALL discard all queued entries immediately and asynchronously.
REQ-030 No write or read SHALL be accepted on the first edge after reset deassertion unless its conditions hold at that edge.

Structure
REQ-031 A shared package SHALL hold the default DATA_WIDTH and DEPTH and a clog2-style width function.
REQ-032 Storage SHALL be a sub-module, dataflow_channel_mem: a DEPTH x DATA_WIDTH array with one write port and an asynchronous read port.

Verification
REQ-033 Fill test: DEPTH=4; write 0x11,0x22,0x33,0x44 on consecutive cycles with no reads -> i_full_n=0 after the 4th edge, count=4, peak=4, t_dout=0x11.
REQ-034 Drain test: from that full state, assert t_read for 4 cycles -> t_dout sequence 0x11,0x22,0x33,0x44; then t_empty_n=0, count=0, peak stays 4.
REQ-035 Full plus simultaneous access: full FIFO, i_write=1 with 0x55 and t_read=1 -> 0x11 consumed, 0x55 dropped, count=3, wr_stall=1 next cycle.
REQ-036 Empty plus simultaneous access: empty FIFO, i_write=1 with 0x66 and t_read=1 -> count=1, t_dout=0x66 next cycle, rd_stall=1.
REQ-037 Wrap test: 10 write/read pairs through a DEPTH=4 FIFO -> data order preserved across pointer wrap, count never exceeds 1, peak=1.
REQ-038 Reset mid-operation: count=3, pulse reset low between edges -> i_full_n=1, t_empty_n=0 and count=0 immediately, with no edge required.
